// File: rtl/ami_mem_resp_queue.sv
// Behavioural AMI memory endpoint: in-order request queue, byte-masked word array,
// fixed-latency read responses held until granted.
module ami_mem_resp_queue #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int SIZE_W  = 64,
  parameter int DEPTH   = 4096,
  parameter int QDEPTH  = 8,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_is_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [SIZE_W-1:0] req_size,
  output logic              req_grant,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [SIZE_W-1:0] resp_size,
  input  logic              resp_grant,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       err_count
);

  // state  | meaning
  // S_IDLE | pop and service queue head (write/error finish here)
  // S_WAIT | read latency countdown
  // S_RESP | read response presented until resp_grant

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int QA_W  = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic              q_wr   [QDEPTH];
  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [SIZE_W-1:0] q_size [QDEPTH];
  logic [DATA_W-1:0] mem    [DEPTH];

  logic [QA_W:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    lat_q, lat_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [SIZE_W-1:0]   resp_size_q, resp_size_d;
  logic [31:0]         rd_count_q, rd_count_d;
  logic [31:0]         wr_count_q, wr_count_d;
  logic [31:0]         err_count_q, err_count_d;

  logic                q_empty, q_full, accept, pop, mem_we;
  logic                h_wr, h_err;
  logic [ADDR_W-1:0]   h_addr;
  logic [DATA_W-1:0]   h_data;
  logic [SIZE_W-1:0]   h_size;
  logic [IDX_W-1:0]    h_idx;
  logic [DATA_W-1:0]   wr_mask;
  logic                unused_addr;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign q_empty   = (wptr_q == rptr_q);
  assign q_full    = (wptr_q[QA_W] != rptr_q[QA_W]) &&
                     (wptr_q[QA_W-1:0] == rptr_q[QA_W-1:0]);
  assign req_grant = req_valid && !q_full;
  assign accept    = req_valid && req_grant;

  assign h_wr   = q_wr[rptr_q[QA_W-1:0]];
  assign h_addr = q_addr[rptr_q[QA_W-1:0]];
  assign h_data = q_data[rptr_q[QA_W-1:0]];
  assign h_size = q_size[rptr_q[QA_W-1:0]];
  assign h_idx  = h_addr[OFF_W +: IDX_W];
  assign unused_addr = ^h_addr[ADDR_W-1:OFF_W+IDX_W];

  assign h_err  = (h_addr[OFF_W-1:0] != '0) || (h_size == '0) ||
                  (h_size[2:0] != 3'd0) || (h_size > SIZE_W'(BYTES));
  assign pop    = (state_q == S_IDLE) && !q_empty;
  assign mem_we = pop && h_wr && !h_err;

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (SIZE_W'(b) < h_size) wr_mask[b*8 +: 8] = 8'hFF;
    end
  end

  // Queue payload and the array carry no reset; only pointers/state do.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_wr[wptr_q[QA_W-1:0]]   <= req_is_write;
      q_addr[wptr_q[QA_W-1:0]] <= req_addr;
      q_data[wptr_q[QA_W-1:0]] <= req_data;
      q_size[wptr_q[QA_W-1:0]] <= req_size;
    end
    if (mem_we) mem[h_idx] <= (mem[h_idx] & ~wr_mask) | (h_data & wr_mask);
  end

  always_comb begin
    wptr_d       = accept ? wptr_q + 1'b1 : wptr_q;
    rptr_d       = pop ? rptr_q + 1'b1 : rptr_q;
    state_d      = state_q;
    lat_d        = lat_q;
    rd_idx_d     = rd_idx_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_size_d  = resp_size_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    err_count_d  = err_count_q;
    case (state_q)
      S_IDLE: begin
        if (!q_empty) begin
          if (h_err) begin
            err_count_d = err_count_q + 32'd1;
          end else if (h_wr) begin
            wr_count_d = wr_count_q + 32'd1;
          end else begin
            resp_size_d = h_size;
            rd_idx_d    = h_idx;
            if (LATENCY == 1) begin
              resp_data_d  = mem[h_idx];
              resp_valid_d = 1'b1;
              state_d      = S_RESP;
            end else begin
              lat_d   = CNT_W'(LATENCY - 1);
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (lat_q == CNT_W'(1)) begin
          resp_data_d  = mem[rd_idx_q];
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_grant) begin
          rd_count_d   = rd_count_q + 32'd1;
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      state_q      <= S_IDLE;
      lat_q        <= '0;
      rd_idx_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_size_q  <= '0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
      err_count_q  <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      state_q      <= state_d;
      lat_q        <= lat_d;
      rd_idx_q     <= rd_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_size_q  <= resp_size_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_size  = resp_size_q;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_ami_mem_resp_queue.sv
// Bench for ami_mem_resp_queue: directed table, backpressure/reset sequences and
// random traffic scored against a transaction-level memory model.
module tb_ami_mem_resp_queue;
  localparam int AW = 64, DW = 512, SW = 64, DEPTH = 4096, QD = 8, LAT = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_is_write = 1'b0, resp_grant = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [SW-1:0] req_size = '0;
  logic          req_grant, resp_valid;
  logic [DW-1:0] resp_data;
  logic [SW-1:0] resp_size;
  logic [31:0]   rd_count, wr_count, err_count;

  ami_mem_resp_queue #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .DEPTH(DEPTH),
                       .QDEPTH(QD), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .req_grant(req_grant), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_size(resp_size), .resp_grant(resp_grant), .rd_count(rd_count),
    .wr_count(wr_count), .err_count(err_count));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: array updated at accept, reads queue expected data.
  typedef struct packed { logic [DW-1:0] data; logic [SW-1:0] size; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] mmem [int];
  int            m_rd = 0, m_wr = 0, m_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic model_accept(input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [SW-1:0] s);
    int idx;
    logic [DW-1:0] word;
    exp_t e;
    if ((a % 64 != 0) || (s == 0) || (s % 8 != 0) || (s > 64)) begin
      m_err++;
      return;
    end
    idx  = int'((a / 64) % DEPTH);
    word = mmem.exists(idx) ? mmem[idx] : '0;
    if (w) begin
      for (int b = 0; b < 64; b++) if (SW'(b) < s) word[b*8 +: 8] = d[b*8 +: 8];
      mmem[idx] = word;
      m_wr++;
    end else begin
      e.data = word;
      e.size = s;
      exp_q.push_back(e);
      m_rd++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_grant) model_accept(req_is_write, req_addr, req_data, req_size);
      if (resp_valid && resp_grant) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got data %0h expected no response", resp_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_resp_data", resp_data, e.data);
          chk("sb_resp_size", DW'(resp_size), DW'(e.size));
        end
      end
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input int budget, output bit ok);
    req_valid = 1'b1; req_is_write = w; req_addr = a; req_data = d; req_size = s;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (req_grant) begin ok = 1'b1; acc_cyc = cyc; end
      @(posedge clk); #2;
    end
    req_valid = 1'b0;
  endtask

  typedef struct packed {
    logic wr; logic [AW-1:0] addr; logic [SW-1:0] size;
    logic [DW-1:0] data; logic err; logic [DW-1:0] want;
  } vec_t;
  vec_t tbl [13];
  int t_rd = 0, t_wr = 0, t_err = 0;

  task automatic run_row(input int r);
    vec_t v;
    bit ok;
    int a, seen, spur;
    v = tbl[r];
    send(v.wr, v.addr, v.data, v.size, 10, ok);
    chk($sformatf("row%0d_grant", r), DW'(ok), DW'(1));
    a = acc_cyc;
    if (v.err) t_err++; else if (v.wr) t_wr++; else t_rd++;
    if (!v.wr && !v.err) begin
      seen = -1;
      for (int i = 0; i < 20 && seen < 0; i++) begin
        @(negedge clk);
        if (resp_valid) seen = cyc;
      end
      chk($sformatf("row%0d_latency", r), DW'(seen - a), DW'(LAT + 1));
      chk($sformatf("row%0d_data", r), resp_data, v.want);
      chk($sformatf("row%0d_size", r), DW'(resp_size), DW'(v.size));
      @(negedge clk);
      chk($sformatf("row%0d_rd_count", r), DW'(rd_count), DW'(t_rd));
    end else begin
      spur = 0;
      repeat (3) begin @(negedge clk); if (resp_valid) spur++; end
      chk($sformatf("row%0d_no_resp", r), DW'(spur), DW'(0));
      chk($sformatf("row%0d_wr_count", r), DW'(wr_count), DW'(t_wr));
      chk($sformatf("row%0d_err_count", r), DW'(err_count), DW'(t_err));
    end
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int nacc, viol, novalid, g, spur, seen;
    logic [DW-1:0] snap, d;
    logic [AW-1:0] a;
    int sel;

    tbl[0]  = '{wr:1'b1, addr:64'h40,    size:64'd64, data:{64{8'hA5}}, err:1'b0, want:'0};
    tbl[1]  = '{wr:1'b0, addr:64'h40,    size:64'd64, data:'0, err:1'b0, want:{64{8'hA5}}};
    tbl[2]  = '{wr:1'b1, addr:64'h80,    size:64'd64, data:{64{8'hFF}}, err:1'b0, want:'0};
    tbl[3]  = '{wr:1'b1, addr:64'h80,    size:64'd8,
                data:{{56{8'hEE}}, 64'h1122334455667788}, err:1'b0, want:'0};
    tbl[4]  = '{wr:1'b0, addr:64'h80,    size:64'd64, data:'0, err:1'b0,
                want:{{56{8'hFF}}, 64'h1122334455667788}};
    tbl[5]  = '{wr:1'b0, addr:64'h41,    size:64'd64, data:'0, err:1'b1, want:'0};
    tbl[6]  = '{wr:1'b1, addr:64'h40,    size:64'd12, data:'0, err:1'b1, want:'0};
    tbl[7]  = '{wr:1'b0, addr:64'h40,    size:64'd0,  data:'0, err:1'b1, want:'0};
    tbl[8]  = '{wr:1'b0, addr:64'h40,    size:64'd64, data:'0, err:1'b0, want:{64{8'hA5}}};
    tbl[9]  = '{wr:1'b1, addr:64'h40100, size:64'd64, data:{8{64'h0123456789ABCDEF}},
                err:1'b0, want:'0};
    tbl[10] = '{wr:1'b0, addr:64'h100,   size:64'd64, data:'0, err:1'b0,
                want:{8{64'h0123456789ABCDEF}}};
    tbl[11] = '{wr:1'b0, addr:64'h80,    size:64'd72, data:'0, err:1'b1, want:'0};
    tbl[12] = '{wr:1'b0, addr:64'h80,    size:64'd16, data:'0, err:1'b0,
                want:{{56{8'hFF}}, 64'h1122334455667788}};

    // Reset behaviour
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", DW'(req_grant), DW'(1));
    chk("rst_resp_valid", DW'(resp_valid), DW'(0));
    chk("rst_resp_data", resp_data, '0);
    chk("rst_resp_size", DW'(resp_size), DW'(0));
    chk("rst_counts", DW'({rd_count, wr_count, err_count}), DW'(0));
    req_valid = 1'b0;
    #1;
    chk("rst_grant_idle", DW'(req_grant), DW'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    spur = 0;
    repeat (5) begin @(negedge clk); if (resp_valid) spur++; end
    chk("rst_release_no_resp", DW'(spur), DW'(0));
    @(posedge clk); #2;

    for (int r = 0; r < 13; r++) run_row(r);

    // Backpressure: 1 in service + QD queued, then the next request must wait.
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
      send(1'b1, AW'((32 + k) * 64), d, 64'd64, 5, ok);
    end
    repeat (3) @(posedge clk);
    #2;
    resp_grant = 1'b0;
    nacc = 0;
    for (int k = 0; k < 9; k++) begin
      send(1'b0, AW'((32 + k) * 64), '0, 64'd64, 1, ok);
      nacc += int'(ok);
    end
    chk("bp_accepted", DW'(nacc), DW'(9));
    req_valid = 1'b1; req_is_write = 1'b0; req_addr = AW'(41 * 64); req_size = 64'd64;
    viol = 0; novalid = 0; snap = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_grant) viol++;
      if (!resp_valid) novalid++;
      if (i == 0) snap = resp_data;
    end
    chk("bp_full_no_grant", DW'(viol), DW'(0));
    chk("bp_resp_held", DW'(novalid), DW'(0));
    chk("bp_resp_stable", resp_data, snap);
    @(posedge clk); #2;
    resp_grant = 1'b1;
    g = cyc;
    send(1'b0, AW'(41 * 64), '0, 64'd64, 10, ok);
    chk("bp_regrant_ok", DW'(ok), DW'(1));
    chk("bp_regrant_cycle", DW'(acc_cyc - g), DW'(2));
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    chk("bp_drained", DW'(exp_q.size()), DW'(0));
    chk("bp_rd_count", DW'(rd_count), DW'(m_rd));
    @(posedge clk); #2;

    // Reset while a response is pending and another read is queued.
    resp_grant = 1'b0;
    send(1'b0, 64'h40, '0, 64'd64, 5, ok);
    send(1'b0, 64'h80, '0, 64'd64, 5, ok);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (resp_valid) seen = 1; end
    chk("mid_resp_seen", DW'(seen), DW'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", DW'(resp_valid), DW'(0));
    chk("mid_rst_resp_data", resp_data, '0);
    chk("mid_rst_counts", DW'({rd_count, wr_count, err_count}), DW'(0));
    exp_q.delete();
    m_rd = 0; m_wr = 0; m_err = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    resp_grant = 1'b1;
    send(1'b0, 64'h40, '0, 64'd64, 5, ok);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (resp_valid) seen = 1; end
    chk("mid_array_kept", resp_data, {64{8'hA5}});
    spur = 0;
    repeat (15) begin @(negedge clk); if (resp_valid) spur++; end
    chk("mid_queue_discarded", DW'(spur), DW'(0));
    chk("mid_rd_count", DW'(rd_count), DW'(1));
    @(posedge clk); #2;

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      req_valid    = ($urandom_range(0, 3) != 0);
      req_is_write = 1'($urandom_range(0, 1));
      a = AW'((32 + $urandom_range(0, 9)) * 64);
      if ($urandom_range(0, 7) == 0) a = a + AW'(DEPTH * 64);
      if ($urandom_range(0, 9) == 0) a = a + AW'($urandom_range(1, 63));
      req_addr = a;
      sel = int'($urandom_range(0, 9));
      req_size = (sel < 9) ? SW'(sel * 8) : (($urandom_range(0, 1) != 0) ? 64'd12 : 64'd72);
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
      req_data   = d;
      resp_grant = ($urandom_range(0, 3) != 0);
      @(posedge clk); #2;
    end
    req_valid  = 1'b0;
    resp_grant = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (QD + 4) @(negedge clk);
    chk("rnd_drained", DW'(exp_q.size()), DW'(0));
    chk("rnd_rd_count", DW'(rd_count), DW'(m_rd));
    chk("rnd_wr_count", DW'(wr_count), DW'(m_wr));
    chk("rnd_err_count", DW'(err_count), DW'(m_err));
    chk("rnd_idle", DW'(resp_valid), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
